// File: rtl/countdown_ctrl.sv
// Countdown application controller: BCD digit entry, preset confirm, ticked BCD
// countdown with pause/resume, and a latched alarm at zero. All outputs registered.
module countdown_ctrl #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                keydown_start,
  input  logic                keydown_confirm,
  input  logic                keydown_clear,
  input  logic                keydown_num,
  input  logic [3:0]          num,
  output logic [4*DIGITS-1:0] display,
  output logic [2:0]          state,
  output logic                running,
  output logic                done,
  output logic                alarm
);

  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [2:0] S_ENTRY = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // BCD decrement with digit-to-digit borrow (a 0 digit becomes 9 and borrows)
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end else begin
        res[4*i +: 4] = v[4*i +: 4];
      end
    end
    return res;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [W-1:0]  preset_q, preset_d;
  logic [W-1:0]  count_q, count_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [W-1:0]  display_q, display_d;
  logic          running_q, done_q, done_d, alarm_q, alarm_d;
  logic          ev_clear, ev_start, ev_confirm, ev_num;
  logic [W-1:0]  dec_s;

  assign ev_clear   = keydown_clear;
  assign ev_start   = keydown_start & ~keydown_clear;
  assign ev_confirm = keydown_confirm & ~keydown_start & ~keydown_clear;
  assign ev_num     = keydown_num & ~keydown_confirm & ~keydown_start & ~keydown_clear
                      & (num <= 4'd9);
  assign dec_s      = bcd_dec(count_q);

  // Next-state logic; only the highest-priority event of the cycle is acted on
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    preset_d = preset_q;
    count_d  = count_q;
    tick_d   = tick_q;
    alarm_d  = alarm_q;
    done_d   = 1'b0;
    if (ev_clear) begin
      state_d = S_ENTRY;
      entry_d = {W{1'b0}};
      count_d = {W{1'b0}};
      tick_d  = {TW{1'b0}};
      alarm_d = 1'b0;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (ev_num) begin
            entry_d = (entry_q << 4) | W'(num);
          end else if (ev_confirm && (entry_q != {W{1'b0}})) begin
            preset_d = entry_q;
            count_d  = entry_q;
            state_d  = S_READY;
          end else begin
            state_d = S_ENTRY;
          end
        end
        S_READY: begin
          if (ev_start) begin
            state_d = S_RUN;
            tick_d  = {TW{1'b0}};
          end else begin
            state_d = S_READY;
          end
        end
        S_RUN: begin
          // Pausing wins over a coinciding tick wrap so the tick value freezes as-is
          if (ev_start) begin
            state_d = S_PAUSE;
          end else if (tick_q == TICK_LAST) begin
            tick_d  = {TW{1'b0}};
            count_d = dec_s;
            if (dec_s == {W{1'b0}}) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              alarm_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_PAUSE: begin
          if (ev_start) begin
            state_d = S_RUN;
          end else if (ev_confirm) begin
            count_d = preset_q;
            tick_d  = {TW{1'b0}};
            state_d = S_READY;
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_DONE: begin
          if (ev_start) begin
            alarm_d = 1'b0;
            count_d = preset_q;
            tick_d  = {TW{1'b0}};
            state_d = S_RUN;
          end else if (ev_confirm) begin
            alarm_d = 1'b0;
            count_d = preset_q;
            state_d = S_READY;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_ENTRY;
        end
      endcase
    end
    display_d = (state_d == S_ENTRY) ? entry_d : count_d;
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_ENTRY;
      entry_q   <= {W{1'b0}};
      preset_q  <= {W{1'b0}};
      count_q   <= {W{1'b0}};
      tick_q    <= {TW{1'b0}};
      display_q <= {W{1'b0}};
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      display_q <= display_d;
      running_q <= (state_d == S_RUN);
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign display = display_q;
  assign state   = state_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule
